// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream width converters.
// Lane masks are computed on a fixed maximum width and trimmed by the user.
package axis_pkg;

    localparam int unsigned DEF_S_DATA_WIDTH = 32;
    localparam int unsigned DEF_M_DATA_WIDTH = 8;

    // Widest converter the helpers support: 512-bit input, 32 lanes.
    localparam int unsigned MAX_RATIO = 32;
    localparam int unsigned MAX_STRB  = 64;

    // Number of narrow lanes that make up one wide beat.
    function automatic int unsigned calc_ratio(
        input int unsigned s_width,
        input int unsigned m_width
    );
        return s_width / m_width;
    endfunction

    // Lane i is kept when any strobe bit inside its slice is set.
    function automatic logic [MAX_RATIO-1:0] lane_keep_mask(
        input logic [MAX_STRB-1:0] strb,
        input int unsigned         ratio,
        input int unsigned         lane_strb
    );
        logic [MAX_RATIO-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            for (int j = 0; j < MAX_STRB; j++) begin
                if ((i < ratio) && (j < lane_strb)) begin
                    mask[i] = mask[i] | strb[i*lane_strb + j];
                end
            end
        end
        return mask;
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic is_onehot(
        input logic [MAX_RATIO-1:0] mask
    );
        return (mask != '0) && ((mask & (mask - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/axis_lane_pick.sv
// Lowest-set-bit priority encoder over the pending-lane mask.
// Produces both a binary lane index and a one-hot grant.
module axis_lane_pick
    import axis_pkg::*;
#(
    parameter int unsigned RATIO = 4,
    parameter int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic [RATIO-1:0] i_pend,
    output logic [IDX_W-1:0] o_idx,
    output logic [RATIO-1:0] o_grant
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        o_idx   = '0;
        o_grant = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_idx   = IDX_W'(i);
                o_grant = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI-Stream converter: one lane per beat, LSB lane first.
// Null lanes are dropped; an all-null tlast beat still emits one empty eop.
module axis_width_downsizer
    import axis_pkg::*;
#(
    parameter int unsigned S_DATA_WIDTH = DEF_S_DATA_WIDTH,
    parameter int unsigned M_DATA_WIDTH = DEF_M_DATA_WIDTH,
    parameter int unsigned S_STRB_WIDTH = S_DATA_WIDTH / 8,
    parameter int unsigned M_STRB_WIDTH = M_DATA_WIDTH / 8,
    parameter int unsigned RATIO        = calc_ratio(S_DATA_WIDTH, M_DATA_WIDTH)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_STRB_WIDTH-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_STRB_WIDTH-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [S_DATA_WIDTH-1:0] r_data;
    logic [S_STRB_WIDTH-1:0] r_strb;
    logic                    r_last;
    logic [RATIO-1:0]        r_pend;
    logic                    r_zero_eop;

    logic [MAX_RATIO-1:0]    w_keep_wide;
    logic [RATIO-1:0]        w_keep;
    logic [RATIO-1:0]        w_load_pend;
    logic [IDX_W-1:0]        w_idx;
    logic [RATIO-1:0]        w_grant;
    logic                    w_valid;
    logic                    w_onehot;
    logic                    w_s_ready;
    logic                    w_s_fire;
    logic                    w_m_fire;
    logic                    w_all_null;
    logic [M_DATA_WIDTH-1:0] w_lane_data;
    logic [M_STRB_WIDTH-1:0] w_lane_strb;

    // Which lanes of the incoming beat carry at least one strobed byte.
    assign w_keep_wide = lane_keep_mask(MAX_STRB'(s_axis_tstrb), RATIO,
                                        M_STRB_WIDTH);
    assign w_keep      = w_keep_wide[RATIO-1:0];

    if (RATIO < MAX_RATIO) begin : gen_keep_tail
        logic w_unused_keep;
        assign w_unused_keep = |w_keep_wide[MAX_RATIO-1:RATIO];
    end

    axis_lane_pick #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_pend  (r_pend),
        .o_idx   (w_idx),
        .o_grant (w_grant)
    );

    assign w_valid    = (r_pend != '0);
    assign w_onehot   = is_onehot(MAX_RATIO'(r_pend));
    assign w_m_fire   = w_valid && m_axis_tready;

    // Ready when idle, or when the last pending lane leaves this cycle.
    assign w_s_ready  = !w_valid || (w_onehot && m_axis_tready);
    assign w_s_fire   = s_axis_tvalid && w_s_ready;

    // An all-null eop beat still needs one output beat to carry tlast.
    assign w_all_null  = (w_keep == '0);
    assign w_load_pend = w_all_null ? (s_axis_tlast ? RATIO'(1) : '0)
                                    : w_keep;

    // Select the presented lane's data and strobes by lane index.
    always_comb begin
        w_lane_data = '0;
        w_lane_strb = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_lane_data = r_data[i*M_DATA_WIDTH +: M_DATA_WIDTH];
                w_lane_strb = r_strb[i*M_STRB_WIDTH +: M_STRB_WIDTH];
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_valid ? w_lane_data : '0;
    assign m_axis_tstrb  = (w_valid && !r_zero_eop) ? w_lane_strb : '0;
    assign m_axis_tlast  = r_last && w_onehot;

    // Hold the accepted wide beat until all of its lanes have gone out.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_data <= '0;
            r_strb <= '0;
            r_last <= 1'b0;
        end else if (w_s_fire) begin
            r_data <= s_axis_tdata;
            r_strb <= s_axis_tstrb;
            r_last <= s_axis_tlast;
        end
    end

    // Track unsent lanes; a new beat overwrites the final cleared lane.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pend     <= '0;
            r_zero_eop <= 1'b0;
        end else if (w_s_fire) begin
            r_pend     <= w_load_pend;
            r_zero_eop <= w_all_null && s_axis_tlast;
        end else if (w_m_fire) begin
            r_pend     <= r_pend & ~w_grant;
        end
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Randomized bench for axis_width_downsizer with a lane-queue model.
// Directed cases first, then a random traffic phase.
module tb_axis_width_downsizer;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       l;
    } lane_t;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_last = 0;
    bit          rnd_mode = 1'b0;
    lane_t       exp_q[$];
    int          out_cycs[$];
    bit          prev_stall = 1'b0;
    logic [9:0]  prev_bus = '0;

    axis_width_downsizer dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference: expand an accepted beat into the lanes it must produce.
    task automatic model_push(input logic [31:0] d, input logic [3:0] s,
                              input logic l);
        int last_kept;
        lane_t e;
        last_kept = -1;
        for (int i = 0; i < 4; i++) if (s[i]) last_kept = i;
        if (last_kept < 0) begin
            if (l) begin
                e.d = d[7:0];
                e.s = 1'b0;
                e.l = 1'b1;
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    e.d = d[i*8 +: 8];
                    e.s = 1'b1;
                    e.l = l && (i == last_kept);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Output randomly stalls only when random mode is on.
    always @(posedge clk) begin
        #1;
        m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: score every output handshake and check stall stability.
    always @(negedge clk) begin
        lane_t e;
        cyc++;
        if (areset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1'b1);
                check("hold_bus", {m_tdata, m_tstrb, m_tlast}, prev_bus);
            end
            if (m_tvalid && m_tready) begin
                check("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("lane_data", m_tdata, e.d);
                    check("lane_strb", m_tstrb, e.s);
                    check("lane_last", m_tlast, e.l);
                end
                out_cycs.push_back(cyc);
                if (m_tlast) n_last++;
            end
            if (s_tvalid && s_tready) model_push(s_tdata, s_tstrb, s_tlast);
            prev_stall = m_tvalid && !m_tready;
            prev_bus   = {m_tdata, m_tstrb, m_tlast};
        end
    end

    // Present one beat and hold it until the handshake edge has passed.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s,
                             input logic l);
        int t;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", s_tready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_tvalid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_idle", (exp_q.size() == 0) && !m_tvalid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_out;
        int base_last;
        logic [31:0] d;
        logic [3:0]  s;
        logic [7:0]  exp_b[4];

        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata", m_tdata, 8'h00);
        check("rst_tstrb", m_tstrb, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tready", s_tready, 1'b1);
        @(posedge clk);
        #1;

        // Full beat, latency 1, ready low for three cycles.
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_beat(32'h44332211, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_valid", m_tvalid, 1'b1);
            check("t1_data", m_tdata, exp_b[k]);
            check("t1_last", m_tlast, k == 3);
            check("t1_sready", s_tready, k == 3);
        end
        @(negedge clk);
        check("t1_done", m_tvalid, 1'b0);
        @(posedge clk);
        #1;

        // Sparse beat: lanes 1 and 3 only.
        send_beat(32'hDDCCBBAA, 4'b1010, 1'b1);
        s_tvalid = 1'b0;
        @(negedge clk);
        check("t2_data0", m_tdata, 8'hBB);
        check("t2_last0", m_tlast, 1'b0);
        @(negedge clk);
        check("t2_data1", m_tdata, 8'hDD);
        check("t2_last1", m_tlast, 1'b1);
        @(negedge clk);
        check("t2_done", m_tvalid, 1'b0);
        @(posedge clk);
        #1;

        // Null beats: silent without tlast, empty eop with tlast.
        send_beat(32'h12345678, 4'h0, 1'b0);
        s_tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_silent", m_tvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        send_beat(32'h000000EE, 4'h0, 1'b1);
        s_tvalid = 1'b0;
        @(negedge clk);
        check("t3_eop_valid", m_tvalid, 1'b1);
        check("t3_eop_strb", m_tstrb, 1'b0);
        check("t3_eop_last", m_tlast, 1'b1);
        check("t3_eop_data", m_tdata, 8'hEE);
        @(negedge clk);
        check("t3_eop_once", m_tvalid, 1'b0);
        @(posedge clk);
        #1;

        // Backpressure: three-beat packet under random stalls.
        base_out  = out_cycs.size();
        base_last = n_last;
        rnd_mode  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            send_beat($urandom, 4'hF, b == 2);
            s_tvalid = 1'b0;
        end
        wait_idle();
        rnd_mode = 1'b0;
        check("t4_count", out_cycs.size() - base_out, 12);
        check("t4_lasts", n_last - base_last, 1);

        // Streaming: eight back-to-back full beats, no bubbles.
        base_out = out_cycs.size();
        for (int b = 0; b < 8; b++) begin
            send_beat($urandom, 4'hF, b == 7);
        end
        s_tvalid = 1'b0;
        wait_idle();
        check("t5_count", out_cycs.size() - base_out, 32);
        if (out_cycs.size() - base_out == 32) begin
            check("t5_span", out_cycs[base_out+31] - out_cycs[base_out], 31);
        end

        // Reset after two of four lanes have gone out.
        send_beat(32'hA4A3A2A1, 4'hF, 1'b1);
        s_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("t6_valid", m_tvalid, 1'b0);
        check("t6_sready", s_tready, 1'b1);
        @(posedge clk);
        #1;
        send_beat(32'h87654321, 4'h3, 1'b1);
        s_tvalid = 1'b0;
        @(negedge clk);
        check("t6_first", m_tdata, 8'h21);
        wait_idle();

        // Random traffic with gaps, sparse strobes and stalls.
        rnd_mode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            send_beat(d, s, $urandom_range(0, 3) == 0);
            s_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        rnd_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
